serial_sub_ctrl: RTL and testbench

//   Sequences one full-subtractor cell (diff = a^b^bin, bout = (~a&b) | (~(a^b)&bin))
//   bit-serially over a WIDTH-bit operand pair, LSB first, one bit per clock.
//   A registered borrow loop and shift registers around the cell form the datapath.

---
 rtl/serial_sub_ctrl_if.sv | 42 ++++
 rtl/serial_sub_ctrl.sv | 95 +++++++++
 tb/tb_serial_sub_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
// Handshake bundle for the bit-serial subtractor controller.
// Upstream operand channel, downstream result channel and busy flag.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_diff,
        output out_bout,
        output busy
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_diff,
        input  out_bout,
        input  busy
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first,
// wrapped in an IDLE/RUN/DONE valid-ready controller.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_nx;

    // The single subtractor cell; the new bit enters res at the MSB.
    always_comb begin
        d      = sh_a[0] ^ sh_b[0] ^ br;
        br_nx  = (~sh_a[0] & sh_b[0])
               | (~(sh_a[0] ^ sh_b[0]) & br);
        res_nx = (res >> 1)
               | (WIDTH'(d) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sh_a          <= '0;
            sh_b          <= '0;
            res           <= '0;
            cnt           <= '0;
            br            <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.out_diff  <= '0;
            bus.out_bout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh_a         <= bus.in_a;
                        sh_b         <= bus.in_b;
                        br           <= bus.in_bin;
                        cnt          <= '0;
                        res          <= '0;
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                RUN: begin
                    res  <= res_nx;
                    br   <= br_nx;
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state         <= DONE;
                        bus.out_diff  <= res_nx;
                        bus.out_bout  <= br_nx;
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH 8, 4 and 1.
// Expected {bout,diff} is queued at accept and popped at handshake.
module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] sb8[$];
    logic [4:0] sb4[$];
    logic [1:0] sb1[$];

    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(4)) if4 ();
    serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

    serial_sub_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
    serial_sub_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    serial_sub_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic send8(input logic [7:0] a, input logic [7:0] b,
                         input logic bin);
        @(negedge clk);
        checks++;
        if (if8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send8_in_ready got %b want 1", if8.in_ready);
        end
        if8.in_a     = a;
        if8.in_b     = b;
        if8.in_bin   = bin;
        if8.in_valid = 1'b1;
        sb8.push_back({1'b0, a} - {1'b0, b} - 9'(bin));
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
    endtask

    // Waits for out_valid (bounded), optionally checks latency, stalls, then handshakes.
    task automatic recv8(input bit chk_lat, input int stall);
        int lat;
        logic [8:0] exp;
        lat = 0;
        while (if8.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp = sb8.pop_front();
        if (if8.out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL recv8_timeout out_valid got %b want 1", if8.out_valid);
            return;
        end
        if (chk_lat) begin
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL recv8_latency got %0d want 8", lat);
            end
        end
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({if8.out_bout, if8.out_diff} !== exp) begin
            errors++;
            $display("FAIL recv8_result got %h want %h",
                     {if8.out_bout, if8.out_diff}, exp);
        end
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b0;
        checks++;
        if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1 || if8.busy !== 1'b0) begin
            errors++;
            $display("FAIL recv8_idle got v=%b r=%b busy=%b want 0 1 0",
                     if8.out_valid, if8.in_ready, if8.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0
            || if8.out_diff !== 8'h00 || if8.out_bout !== 1'b0) begin
            errors++;
            $display("FAIL reset8 got r=%b v=%b busy=%b d=%h b=%b want 1 0 0 00 0",
                     if8.in_ready, if8.out_valid, if8.busy, if8.out_diff, if8.out_bout);
        end
        checks++;
        if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0 || if4.busy !== 1'b0
            || if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0 || if1.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_small got r4=%b v4=%b r1=%b v1=%b want 1 0 1 0",
                     if4.in_ready, if4.out_valid, if1.in_ready, if1.out_valid);
        end
    endtask

    task automatic test_basic();
        send8(8'h05, 8'h03, 1'b0);
        checks++;
        if (if8.busy !== 1'b1 || if8.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy got busy=%b r=%b want 1 0", if8.busy, if8.in_ready);
        end
        recv8(1'b1, 0);
    endtask

    task automatic test_boundary();
        send8(8'h00, 8'h01, 1'b0);
        recv8(1'b1, 0);
        send8(8'hFF, 8'hFF, 1'b1);
        recv8(1'b1, 0);
        send8(8'h80, 8'h7F, 1'b1);
        recv8(1'b1, 0);
    endtask

    task automatic test_backpressure();
        int n;
        logic [8:0] exp;
        send8(8'h5A, 8'h21, 1'b1);
        exp = sb8[0];
        n = 0;
        while (if8.out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if8.in_valid = i[0];
            if8.in_a     = 8'(i * 37);
            if8.in_b     = 8'(i * 11);
            @(posedge clk);
            #1;
            checks++;
            if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0
                || {if8.out_bout, if8.out_diff} !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b r=%b res=%h want 1 0 %h",
                         i, if8.out_valid, if8.in_ready,
                         {if8.out_bout, if8.out_diff}, exp);
            end
        end
        if8.in_valid = 1'b0;
        recv8(1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (if8.busy !== 1'b0 || if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_ghost got busy=%b v=%b want 0 0", if8.busy, if8.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        send8(8'h33, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb8.pop_back());
        checks++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got r=%b v=%b busy=%b want 1 0 0",
                     if8.in_ready, if8.out_valid, if8.busy);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (if8.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_pulse got %0d want 0", seen);
        end
        send8(8'h10, 8'h01, 1'b0);
        recv8(1'b1, 0);
    endtask

    task automatic test_operand_change();
        int n;
        send8(8'hC3, 8'h5D, 1'b0);
        n = 0;
        while (if8.out_valid !== 1'b1 && n < 100) begin
            if8.in_a   = 8'($urandom);
            if8.in_b   = 8'($urandom);
            if8.in_bin = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL opchg_latency got %0d want 8", n);
        end
        recv8(1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send8(a, b, 1'($urandom));
            recv8(1'b1, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_sweep4();
        logic [4:0] exp;
        bit done;
        int n;
        for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if4.in_a     = 4'(a);
            if4.in_b     = 4'(b);
            if4.in_bin   = 1'(c);
            if4.in_valid = 1'b1;
            sb4.push_back(5'(a) - 5'(b) - 5'(c));
            @(posedge clk);
            #1;
            if4.in_valid = 1'b0;
            done = 0;
            n = 0;
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
                if (if4.out_valid === 1'b1 && $urandom_range(0, 1) == 1) begin
                    exp = sb4.pop_front();
                    checks++;
                    if ({if4.out_bout, if4.out_diff} !== exp) begin
                        errors++;
                        $display("FAIL sweep4 a=%0d b=%0d bin=%0d got %h want %h",
                                 a, b, c, {if4.out_bout, if4.out_diff}, exp);
                    end
                    if4.out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    if4.out_ready = 1'b0;
                    done = 1;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL sweep4_timeout a=%0d b=%0d got no out_valid want 1", a, b);
                sb4.delete();
            end
        end
    endtask

    task automatic test_sweep1();
        logic [1:0] exp;
        bit done;
        int n;
        for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if1.in_a     = 1'(a);
            if1.in_b     = 1'(b);
            if1.in_bin   = 1'(c);
            if1.in_valid = 1'b1;
            sb1.push_back(2'(a) - 2'(b) - 2'(c));
            @(posedge clk);
            #1;
            if1.in_valid = 1'b0;
            done = 0;
            n = 0;
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
                if (if1.out_valid === 1'b1 && $urandom_range(0, 1) == 1) begin
                    exp = sb1.pop_front();
                    checks++;
                    if ({if1.out_bout, if1.out_diff} !== exp) begin
                        errors++;
                        $display("FAIL sweep1 a=%0d b=%0d bin=%0d got %b want %b",
                                 a, b, c, {if1.out_bout, if1.out_diff}, exp);
                    end
                    if1.out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    if1.out_ready = 1'b0;
                    done = 1;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL sweep1_timeout a=%0d b=%0d got no out_valid want 1", a, b);
                sb1.delete();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0;
        if8.in_bin = 1'b0; if8.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0;
        if4.in_bin = 1'b0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0;
        if1.in_bin = 1'b0; if1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_mid_run();
        test_operand_change();
        test_back_to_back();
        test_sweep4();
        test_sweep1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
